// File: rtl/tmr_vote_monitor.sv
// Majority voter for a triplicated bus with replica-disagreement monitoring:
// per-replica consecutive-mismatch counters, sticky faulty flags, health state, error counter.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// ALL_OK   | no replica flagged faulty
// DEGRADED | exactly one replica flagged faulty; vote still backed by two
// FAILED   | two or more replicas flagged; voted word is untrustworthy
module tmr_vote_monitor #(
    parameter int WIDTH       = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int FAIL_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     inA,
    input  logic [WIDTH-1:0]     inB,
    input  logic [WIDTH-1:0]     inC,
    input  logic                 in_valid,
    input  logic                 clr,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    output logic [2:0]           mism,
    output logic [2:0]           faulty,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ALL_OK   = 2'd0,
        DEGRADED = 2'd1,
        FAILED   = 2'd2
    } health_e;

    localparam logic [7:0]           THRESH  = 8'(FAIL_THRESH);
    localparam logic [CNT_WIDTH-1:0] ERR_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] ERR_ONE = CNT_WIDTH'(1);

    logic [WIDTH-1:0]     vote;
    logic [2:0]           mism_now;

    logic [WIDTH-1:0]     out_q,       out_d;
    logic                 out_valid_q, out_valid_d;
    logic [2:0]           mism_q,      mism_d;
    logic [2:0]           faulty_q,    faulty_d;
    health_e              state_q,     state_d;
    logic [CNT_WIDTH-1:0] err_cnt_q,   err_cnt_d;
    logic [7:0]           cons_q [3];
    logic [7:0]           cons_d [3];

    always_comb begin
        vote     = (inA & inB) | (inB & inC) | (inA & inC);
        mism_now = {inC != vote, inB != vote, inA != vote};

        out_valid_d = in_valid;
        out_d       = out_q;
        mism_d      = mism_q;
        if (in_valid) begin
            out_d  = vote;
            mism_d = mism_now;
        end

        // A word arriving together with clr is voted but never scored.
        for (int i = 0; i < 3; i++) begin
            cons_d[i]   = cons_q[i];
            faulty_d[i] = faulty_q[i];
            if (clr) begin
                cons_d[i]   = 8'd0;
                faulty_d[i] = 1'b0;
            end else if (in_valid) begin
                if (mism_now[i])
                    cons_d[i] = (cons_q[i] == 8'hFF) ? cons_q[i] : cons_q[i] + 8'd1;
                else
                    cons_d[i] = 8'd0;
                if (cons_d[i] >= THRESH)
                    faulty_d[i] = 1'b1;
            end
        end

        err_cnt_d = err_cnt_q;
        if (clr)
            err_cnt_d = '0;
        else if (in_valid && (|mism_now) && (err_cnt_q != ERR_MAX))
            err_cnt_d = err_cnt_q + ERR_ONE;

        // Health follows the registered flags, so it trails them by one edge.
        case (faulty_q)
            3'b000:                 state_d = ALL_OK;
            3'b001, 3'b010, 3'b100: state_d = DEGRADED;
            default:                state_d = FAILED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            mism_q      <= 3'b000;
            faulty_q    <= 3'b000;
            state_q     <= ALL_OK;
            err_cnt_q   <= '0;
            for (int i = 0; i < 3; i++)
                cons_q[i] <= 8'd0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            mism_q      <= mism_d;
            faulty_q    <= faulty_d;
            state_q     <= state_d;
            err_cnt_q   <= err_cnt_d;
            for (int i = 0; i < 3; i++)
                cons_q[i] <= cons_d[i];
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign mism      = mism_q;
    assign faulty    = faulty_q;
    assign state     = state_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Scoreboard bench for tmr_vote_monitor: a default instance plus a CNT_WIDTH=2 instance
// for saturation, both driven identically and compared against a behavioural model.
module tb_tmr_vote_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] inA, inB, inC;
    logic       in_valid, clr;

    logic [7:0]  out,   out_s;
    logic        out_valid, out_valid_s;
    logic [2:0]  mism,  mism_s;
    logic [2:0]  faulty, faulty_s;
    logic [1:0]  state, state_s;
    logic [15:0] err_cnt;
    logic [1:0]  err_cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tmr_vote_monitor #(.WIDTH(8), .CNT_WIDTH(16), .FAIL_THRESH(4)) dut (
        .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC),
        .in_valid(in_valid), .clr(clr), .out(out), .out_valid(out_valid),
        .mism(mism), .faulty(faulty), .state(state), .err_cnt(err_cnt)
    );

    tmr_vote_monitor #(.WIDTH(8), .CNT_WIDTH(2), .FAIL_THRESH(4)) dut_s (
        .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC),
        .in_valid(in_valid), .clr(clr), .out(out_s), .out_valid(out_valid_s),
        .mism(mism_s), .faulty(faulty_s), .state(state_s), .err_cnt(err_cnt_s)
    );

    typedef struct {
        logic [7:0]  out;
        logic        ov;
        logic [2:0]  mism;
        logic [2:0]  faulty;
        logic [1:0]  st;
        logic [15:0] err;
        logic [1:0]  errs;
    } exp_t;

    exp_t sb[$];

    // behavioural model state
    logic [7:0]  m_out;
    logic        m_ov;
    logic [2:0]  m_mism, m_faulty;
    logic [1:0]  m_st;
    logic [15:0] m_err;
    logic [1:0]  m_errs;
    int          m_cons[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic [7:0] a, b, c, input logic v, cl, rs);
        logic [7:0] vt;
        logic [2:0] mm;
        int         nf;
        if (rs) begin
            m_out = 0; m_ov = 0; m_mism = 0; m_faulty = 0; m_st = 0;
            m_err = 0; m_errs = 0;
            for (int i = 0; i < 3; i++) m_cons[i] = 0;
        end else begin
            nf = int'(m_faulty[0]) + int'(m_faulty[1]) + int'(m_faulty[2]);
            for (int k = 0; k < 8; k++)
                vt[k] = (int'(a[k]) + int'(b[k]) + int'(c[k])) >= 2;
            mm = {c != vt, b != vt, a != vt};
            m_ov = v;
            if (v) begin
                m_out  = vt;
                m_mism = mm;
            end
            if (cl) begin
                for (int i = 0; i < 3; i++) m_cons[i] = 0;
                m_faulty = 0; m_err = 0; m_errs = 0;
            end else if (v) begin
                for (int i = 0; i < 3; i++) begin
                    m_cons[i] = mm[i] ? ((m_cons[i] < 255) ? m_cons[i] + 1 : 255) : 0;
                    if (m_cons[i] >= 4) m_faulty[i] = 1'b1;
                end
                if (mm != 0) begin
                    if (m_err  != 16'hFFFF) m_err  = m_err + 1;
                    if (m_errs != 2'd3)     m_errs = m_errs + 1;
                end
            end
            m_st = (nf == 0) ? 2'd0 : (nf == 1) ? 2'd1 : 2'd2;
        end
    endtask

    // Drive one cycle, push the expectation, then pop and compare after the edge.
    task automatic cyc(input logic [7:0] a, b, c, input logic v, cl, rs);
        exp_t e;
        @(negedge clk);
        inA = a; inB = b; inC = c; in_valid = v; clr = cl; rst = rs;
        model_step(a, b, c, v, cl, rs);
        e.out = m_out; e.ov = m_ov; e.mism = m_mism; e.faulty = m_faulty;
        e.st = m_st; e.err = m_err; e.errs = m_errs;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("out",       32'(out),       32'(e.out));
        check("out_valid", 32'(out_valid), 32'(e.ov));
        check("mism",      32'(mism),      32'(e.mism));
        check("faulty",    32'(faulty),    32'(e.faulty));
        check("state",     32'(state),     32'(e.st));
        check("err_cnt",   32'(err_cnt),   32'(e.err));
        check("err_cnt_s", 32'(err_cnt_s), 32'(e.errs));
        check("out_s",     32'(out_s),     32'(e.out));
        check("faulty_s",  32'(faulty_s),  32'(e.faulty));
    endtask

    task automatic word(input logic [7:0] a, b, c);
        cyc(a, b, c, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(8'h00, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        inA = 0; inB = 0; inC = 0; in_valid = 0; clr = 0; rst = 1;
        for (int i = 0; i < 3; i++) m_cons[i] = 0;
        m_out = 0; m_ov = 0; m_mism = 0; m_faulty = 0; m_st = 0; m_err = 0; m_errs = 0;

        // reset with random inputs
        for (int i = 0; i < 2; i++)
            cyc(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        check("rst_out", 32'(out), 32'h0);
        check("rst_state", 32'(state), 32'h0);

        // clean word
        word(8'h5A, 8'h5A, 8'h5A);
        check("clean_out", 32'(out), 32'h5A);

        // single replica upset, then clean
        for (int i = 0; i < 3; i++) begin
            word(8'h5A, 8'h5B, 8'h5A);
            check("upset_mism", 32'(mism), 32'b010);
        end
        word(8'h5A, 8'h5A, 8'h5A);
        check("upset_err", 32'(err_cnt), 32'd3);
        check("upset_faulty", 32'(faulty), 32'd0);
        idle();

        // replica B failure, degraded one cycle later, then clr
        for (int i = 0; i < 4; i++) word(8'h5A, 8'h5B, 8'h5A);
        check("b_faulty", 32'(faulty), 32'b010);
        check("b_state_lag", 32'(state), 32'd0);
        idle();
        check("b_degraded", 32'(state), 32'd1);
        cyc(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0);
        check("clr_faulty", 32'(faulty), 32'd0);
        check("clr_err", 32'(err_cnt), 32'd0);
        idle();
        check("clr_state", 32'(state), 32'd0);

        // consecutive counts survive idle gaps
        word(8'h11, 8'h10, 8'h11);
        word(8'h22, 8'h20, 8'h22);
        idle(); idle();
        word(8'h33, 8'h30, 8'h33);
        check("gap_not_yet", 32'(faulty), 32'd0);
        idle();
        word(8'h44, 8'h40, 8'h44);
        check("gap_faulty", 32'(faulty), 32'b010);

        // clr with a simultaneous mismatching word: voted, not scored
        cyc(8'h77, 8'h77, 8'h70, 1'b1, 1'b1, 1'b0);
        check("clr_vote", 32'(out), 32'h77);
        check("clr_mism", 32'(mism), 32'b100);
        check("clr_nocount", 32'(err_cnt), 32'd0);
        idle();

        // double fault in disjoint bits
        for (int i = 0; i < 4; i++) word(8'h3C ^ 8'h01, 8'h3C, 8'h3C ^ 8'h80);
        check("dbl_out", 32'(out), 32'h3C);
        check("dbl_faulty", 32'(faulty), 32'b101);
        check("sat_err_s", 32'(err_cnt_s), 32'd3);
        idle();
        check("dbl_failed", 32'(state), 32'd2);
        word(8'h3C ^ 8'h01, 8'h3C, 8'h3C ^ 8'h80);
        check("sat_stick", 32'(err_cnt_s), 32'd3);

        // same-bit double fault: the vote follows the two wrong replicas
        word(8'h81, 8'h81, 8'h80);
        check("same_bit_out", 32'(out), 32'h81);
        check("same_bit_mism", 32'(mism), 32'b100);

        // random traffic, clr and valid mixed in
        for (int i = 0; i < 40; i++) begin
            logic [7:0] base;
            base = 8'($urandom);
            cyc(($urandom_range(0, 3) == 0) ? base ^ 8'($urandom) : base,
                ($urandom_range(0, 3) == 0) ? base ^ 8'($urandom) : base,
                ($urandom_range(0, 3) == 0) ? base ^ 8'($urandom) : base,
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), 1'b0);
        end

        // reset overrides clr and valid
        cyc(8'hAA, 8'h55, 8'hAA, 1'b1, 1'b1, 1'b1);
        check("rst_override_ov", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tmr_vote_monitor.md
Name: tmr_vote_monitor

Overview:
- Receiving end of a triplicated datapath: takes the three replicas (A/B/C) of a bus produced by a triplicated domain and returns a single majority-voted, registered word.
- Monitors replica disagreement: per-replica consecutive-mismatch tracking, sticky faulty flags, a health state machine and a saturating error counter.
- Sits at the boundary where triplicated logic feeds non-triplicated logic or a readout/slow-control interface.

Parameters:
- WIDTH, 8, data width of each replica and of the voted output.
- CNT_WIDTH, 16, width of the error event counter.
- FAIL_THRESH, 4, consecutive valid mismatching words after which a replica is marked faulty (legal range 1..255).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- inA  input  WIDTH  replica A data.
- inB  input  WIDTH  replica B data.
- inC  input  WIDTH  replica C data.
- in_valid  input  1  replicas carry a word this cycle.
- clr  input  1  synchronous clear of counters, sticky flags and health state.
- out  output  WIDTH  voted word, registered.
- out_valid  output  1  out holds a new word this cycle.
- mism  output  3  {C,B,A}: replica differed from the vote on the last valid word.
- faulty  output  3  {C,B,A}: sticky faulty flags.
- state  output  2  health: 0 = ALL_OK, 1 = DEGRADED, 2 = FAILED.
- err_cnt  output  CNT_WIDTH  count of valid words with any mismatch; saturating.

Behaviour:
- Reset (rst=1 at an edge): out=0, out_valid=0, mism=0, faulty=0, state=ALL_OK, err_cnt=0, internal consecutive counters=0. Reset overrides every other input.
- Vote: bitwise majority, V = (A&B)|(B&C)|(A&C).
- Latency: in_valid=1 in cycle N gives out=V and out_valid=1 in cycle N+1.
- in_valid=0: out_valid=0 next cycle; out, mism and the consecutive counters hold.
- Per-replica mismatch on each valid word: mX = (inX != V); mism updates with the same 1-cycle latency as out.
- Consecutive counter per replica, 8-bit saturating:
  - valid word with mX=1: increment;
  - valid word with mX=0: reset to 0.
- faulty[X]: set when the counter value after the update reaches FAIL_THRESH. Sticky until clr or rst.
- Health state is combinational on the faulty flags but registered:
  - 0 faulty → ALL_OK;
  - 1 faulty → DEGRADED;
  - 2 or 3 faulty → FAILED.
  - The state therefore updates one cycle after the faulty flags update.
- FAILED: out and out_valid continue unchanged in behaviour. FAILED is the signal to downstream that the vote is untrustworthy.
- err_cnt: +1 per valid word where any mX=1; saturates at 2^CNT_WIDTH-1 and never wraps.
- clr=1 at an edge:
  - err_cnt, consecutive counters and faulty return to 0; state returns to ALL_OK on the next edge.
  - A simultaneous valid word is still voted and output (out, out_valid, mism update normally), but its mismatches are not counted.
- Two replicas wrong in different bits: the vote is still correct per bit, and both replicas are flagged.
- Two replicas wrong in the same bit: the vote follows them. The correct replica is flagged; this is a known limitation.

Test Plan:
- Reset: rst high 2 cycles with random inputs → out=0, out_valid=0, faulty=0, state=0, err_cnt=0.
- Clean words: A=B=C=0x5A, in_valid=1 → next cycle out=0x5A, out_valid=1, mism=0, err_cnt unchanged.
- Single replica upset: A=0x5A, B=0x5B, C=0x5A for 3 valid words, then clean → out=0x5A throughout, mism=3'b010 for 3 cycles, err_cnt=3, faulty=0.
- Replica B failure and recovery:
  - B differs for 4 consecutive valid words → faulty=3'b010 after the 4th, state=DEGRADED one cycle later;
  - then apply clr → faulty=0, state=ALL_OK, err_cnt=0.
- Double fault: A and C each differ for 4 words in disjoint bits (A=0x01^V, C=0x80^V) → out=V, faulty=3'b101, state=FAILED.
- Saturation and gaps:
  - CNT_WIDTH=2 with 5 mismatching words → err_cnt sticks at 3;
  - mismatches interleaved with in_valid=0 idle cycles → consecutive counts are kept across the gaps.
